// File: rtl/spi_pkg.sv
// Shared SPI constants and types for the target and the ControlRegs SPI master.
package spi_pkg;
  localparam int SPI_WORD_BITS = 32;
  localparam int SPI_CNT_W     = 6;
  localparam logic [SPI_WORD_BITS-1:0] SPI_TX_IDLE = 32'hFFFF_FFFF;

  // Transfer lengths the master side can issue
  localparam int SPI_XFER_8  = 8;
  localparam int SPI_XFER_16 = 16;
  localparam int SPI_XFER_32 = 32;

  typedef enum logic {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_state_e;
endpackage

// File: rtl/spi_if.sv
// SPI pins plus the TX/RX word handshakes of the SPI target.
interface spi_if;
  import spi_pkg::*;

  logic                     IN_SPI_clk;
  logic                     IN_SPI_mosi;
  logic                     IN_SPI_cs_n;
  logic                     OUT_SPI_miso;
  logic [SPI_WORD_BITS-1:0] IN_txData;
  logic                     IN_txValid;
  logic                     OUT_txReady;
  logic [SPI_WORD_BITS-1:0] OUT_rxData;
  logic [SPI_CNT_W-1:0]     OUT_rxBits;
  logic                     OUT_rxValid;
  logic                     IN_rxReady;
  logic                     OUT_txUnderrun;
  logic                     OUT_rxOverflow;
  logic                     IN_clrErr;

  modport slave (
    input  IN_SPI_clk, IN_SPI_mosi, IN_SPI_cs_n, IN_txData, IN_txValid,
           IN_rxReady, IN_clrErr,
    output OUT_SPI_miso, OUT_txReady, OUT_rxData, OUT_rxBits, OUT_rxValid,
           OUT_txUnderrun, OUT_rxOverflow
  );

  modport master (
    output IN_SPI_clk, IN_SPI_mosi, IN_SPI_cs_n, IN_txData, IN_txValid,
           IN_rxReady, IN_clrErr,
    input  OUT_SPI_miso, OUT_txReady, OUT_rxData, OUT_rxBits, OUT_rxValid,
           OUT_txUnderrun, OUT_rxOverflow
  );
endinterface

// File: rtl/spi_shift_core.sv
// RX/TX shift registers, bit counter and SCK rise detection for the SPI target.
module spi_shift_core
  import spi_pkg::*;
#(
  parameter int WORD_BITS = SPI_WORD_BITS,
  parameter logic [SPI_WORD_BITS-1:0] TX_IDLE = SPI_TX_IDLE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sck,
  input  logic                     mosi,
  input  logic                     cs_n,
  input  logic                     active,
  input  logic                     close,
  input  logic                     load,
  input  logic [SPI_WORD_BITS-1:0] load_word,
  output logic                     miso,
  output logic                     wrap,
  output logic [SPI_CNT_W-1:0]     bit_cnt,
  output logic [SPI_WORD_BITS-1:0] rx_word
);
  localparam logic [SPI_CNT_W-1:0] LAST_BIT = SPI_CNT_W'(WORD_BITS - 1);

  logic                     sck_prev;
  logic                     rise;
  logic                     step;
  logic [SPI_WORD_BITS-1:0] rx_shift;
  logic [SPI_WORD_BITS-1:0] tx_shift;
  logic [SPI_WORD_BITS-1:0] rx_next;

  // A rise coinciding with cs_n going high is not a data edge
  assign rise    = sck & ~sck_prev;
  assign step    = active & ~cs_n & rise;
  assign wrap    = step && (bit_cnt == LAST_BIT);
  assign rx_next = {rx_shift[SPI_WORD_BITS-2:0], mosi};
  assign rx_word = wrap ? rx_next : rx_shift;
  assign miso    = tx_shift[SPI_WORD_BITS-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_prev <= 1'b0;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= TX_IDLE;
    end else begin
      sck_prev <= sck;
      // Cleared after every delivery so a short word arrives right-aligned
      if (close || wrap) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (step) begin
        bit_cnt  <= bit_cnt + 1'b1;
        rx_shift <= rx_next;
      end
      if (load)
        tx_shift <= load_word;
      else if (step)
        tx_shift <= {tx_shift[SPI_WORD_BITS-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: frame FSM, TX holding register, RX holding register and sticky errors.
module spi_target
  import spi_pkg::*;
#(
  parameter int WORD_BITS = SPI_WORD_BITS,
  parameter logic [SPI_WORD_BITS-1:0] TX_IDLE = SPI_TX_IDLE
) (
  input  logic clk,
  input  logic rst,
  spi_if.slave bus
);
  spi_state_e               state, state_next;
  logic                     start, close, load, wrap, deliver, rx_accept, tx_write;
  logic [SPI_CNT_W-1:0]     bit_cnt;
  logic [SPI_CNT_W-1:0]     deliver_bits;
  logic [SPI_WORD_BITS-1:0] rx_word;
  logic [SPI_WORD_BITS-1:0] load_word;
  logic                     hold_valid;
  logic [SPI_WORD_BITS-1:0] hold_data;
  logic                     rx_valid;
  logic [SPI_WORD_BITS-1:0] rx_data;
  logic [SPI_CNT_W-1:0]     rx_bits;
  logic                     tx_underrun, rx_overflow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SPI_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    close      = 1'b0;
    case (state)
      SPI_IDLE: if (!bus.IN_SPI_cs_n) begin
        state_next = SPI_ACTIVE;
        start      = 1'b1;
      end
      SPI_ACTIVE: if (bus.IN_SPI_cs_n) begin
        state_next = SPI_IDLE;
        close      = 1'b1;
      end
      default: state_next = SPI_IDLE;
    endcase
  end

  spi_shift_core #(.WORD_BITS(WORD_BITS), .TX_IDLE(TX_IDLE)) u_core (
    .clk       (clk),
    .rst       (rst),
    .sck       (bus.IN_SPI_clk),
    .mosi      (bus.IN_SPI_mosi),
    .cs_n      (bus.IN_SPI_cs_n),
    .active    (state == SPI_ACTIVE),
    .close     (close),
    .load      (load),
    .load_word (load_word),
    .miso      (bus.OUT_SPI_miso),
    .wrap      (wrap),
    .bit_cnt   (bit_cnt),
    .rx_word   (rx_word)
  );

  // Loads happen only with cs_n low, so an empty holding register is always an underrun
  assign load         = start | wrap;
  assign load_word    = hold_valid ? hold_data : TX_IDLE;
  assign tx_write     = bus.IN_txValid & ~hold_valid;
  assign deliver      = wrap | (close & (bit_cnt != '0));
  assign deliver_bits = wrap ? SPI_CNT_W'(WORD_BITS) : bit_cnt;
  assign rx_accept    = ~rx_valid | bus.IN_rxReady;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid  <= 1'b0;
      hold_data   <= '0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      rx_bits     <= '0;
      tx_underrun <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      if (load && hold_valid) hold_valid <= 1'b0;
      if (tx_write) begin
        hold_valid <= 1'b1;
        hold_data  <= bus.IN_txData;
      end

      if (deliver && rx_accept) begin
        rx_valid <= 1'b1;
        rx_data  <= rx_word;
        rx_bits  <= deliver_bits;
      end else if (rx_valid && bus.IN_rxReady) begin
        rx_valid <= 1'b0;
      end

      if (load && !hold_valid) tx_underrun <= 1'b1;
      else if (bus.IN_clrErr)  tx_underrun <= 1'b0;
      if (deliver && !rx_accept) rx_overflow <= 1'b1;
      else if (bus.IN_clrErr)    rx_overflow <= 1'b0;
    end
  end

  assign bus.OUT_txReady    = ~hold_valid;
  assign bus.OUT_rxValid    = rx_valid;
  assign bus.OUT_rxData     = rx_data;
  assign bus.OUT_rxBits     = rx_bits;
  assign bus.OUT_txUnderrun = tx_underrun;
  assign bus.OUT_rxOverflow = rx_overflow;
endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: acts as a mode-0 SPI master with a 2-clk SCK period.
module tb_spi_target;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  spi_if bus();

  spi_target dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // One SCK period: low cycle (MISO sampled), then high cycle
  task automatic send_bit(input logic b, output logic m);
    @(posedge clk); #1;
    bus.IN_SPI_clk  = 1'b0;
    bus.IN_SPI_mosi = b;
    m = bus.OUT_SPI_miso;
    @(posedge clk); #1;
    bus.IN_SPI_clk = 1'b1;
  endtask

  task automatic xfer(input int n, input logic [31:0] w, output logic [31:0] m);
    logic b;
    m = '0;
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(w[i], b);
      m = {m[30:0], b};
    end
    @(posedge clk); #1;
    bus.IN_SPI_clk = 1'b0;
  endtask

  task automatic cs_low();
    @(posedge clk); #1;
    bus.IN_SPI_cs_n = 1'b0;
  endtask

  task automatic cs_high();
    @(posedge clk); #1;
    bus.IN_SPI_cs_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic pulse_rx_ready();
    @(posedge clk); #1;
    bus.IN_rxReady = 1'b1;
    @(posedge clk); #1;
    bus.IN_rxReady = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    bus.IN_clrErr = 1'b1;
    @(posedge clk); #1;
    bus.IN_clrErr = 1'b0;
  endtask

  initial begin
    logic [31:0] m;
    logic        b;
    bus.IN_SPI_clk  = 1'b0;
    bus.IN_SPI_mosi = 1'b0;
    bus.IN_SPI_cs_n = 1'b1;
    bus.IN_txData   = '0;
    bus.IN_txValid  = 1'b0;
    bus.IN_rxReady  = 1'b0;
    bus.IN_clrErr   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_miso",     {31'd0, bus.OUT_SPI_miso},   32'd1);
    check("rst_txready",  {31'd0, bus.OUT_txReady},    32'd1);
    check("rst_rxvalid",  {31'd0, bus.OUT_rxValid},    32'd0);
    check("rst_underrun", {31'd0, bus.OUT_txUnderrun}, 32'd0);
    check("rst_overflow", {31'd0, bus.OUT_rxOverflow}, 32'd0);
    rst = 1'b1;

    // Queued TX word, full 32-bit word
    @(posedge clk); #1;
    bus.IN_txData  = 32'hA5A5_0F0F;
    bus.IN_txValid = 1'b1;
    @(posedge clk); #1;
    bus.IN_txValid = 1'b0;
    check("tx_held_ready", {31'd0, bus.OUT_txReady}, 32'd0);
    cs_low();
    xfer(32, 32'h1234_5678, m);
    check("w32_miso",    m,                               32'hA5A5_0F0F);
    check("w32_valid",   {31'd0, bus.OUT_rxValid},        32'd1);
    check("w32_data",    bus.OUT_rxData,                  32'h1234_5678);
    check("w32_bits",    {26'd0, bus.OUT_rxBits},         32'd32);
    check("w32_txready", {31'd0, bus.OUT_txReady},        32'd1);
    check("w32_wrap_ur", {31'd0, bus.OUT_txUnderrun},     32'd1);
    pulse_rx_ready();
    check("w32_consumed", {31'd0, bus.OUT_rxValid}, 32'd0);
    cs_high();
    pulse_clr();

    // 8-bit partial word closed by cs_n
    cs_low();
    xfer(8, 32'h0000_00C3, m);
    check("w8_none_yet", {31'd0, bus.OUT_rxValid}, 32'd0);
    cs_high();
    check("w8_valid", {31'd0, bus.OUT_rxValid}, 32'd1);
    check("w8_data",  bus.OUT_rxData,           32'h0000_00C3);
    check("w8_bits",  {26'd0, bus.OUT_rxBits},  32'd8);
    pulse_rx_ready();
    check("w8_single", {31'd0, bus.OUT_rxValid}, 32'd0);
    pulse_clr();

    // Underrun: nothing queued
    check("ur_clear_before", {31'd0, bus.OUT_txUnderrun}, 32'd0);
    cs_low();
    xfer(16, 32'h0000_1357, m);
    check("ur_miso",   m,                           32'h0000_FFFF);
    check("ur_flag",   {31'd0, bus.OUT_txUnderrun}, 32'd1);
    cs_high();
    check("ur_data",   bus.OUT_rxData,              32'h0000_1357);
    check("ur_bits",   {26'd0, bus.OUT_rxBits},     32'd16);
    pulse_rx_ready();
    pulse_clr();
    check("ur_cleared", {31'd0, bus.OUT_txUnderrun}, 32'd0);

    // Overflow: two words with the consumer stalled
    cs_low();
    xfer(32, 32'hDEAD_BEEF, m);
    check("ov_first_valid", {31'd0, bus.OUT_rxValid},    32'd1);
    check("ov_no_flag_yet", {31'd0, bus.OUT_rxOverflow}, 32'd0);
    xfer(32, 32'h0BAD_F00D, m);
    check("ov_flag",       {31'd0, bus.OUT_rxOverflow}, 32'd1);
    check("ov_kept_first", bus.OUT_rxData,              32'hDEAD_BEEF);
    cs_high();
    pulse_rx_ready();
    check("ov_drained", {31'd0, bus.OUT_rxValid}, 32'd0);
    pulse_clr();
    check("ov_cleared", {31'd0, bus.OUT_rxOverflow}, 32'd0);

    // Reset in the middle of a frame
    cs_low();
    for (int i = 0; i < 13; i++) send_bit(1'b1, b);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.IN_SPI_clk  = 1'b0;
    bus.IN_SPI_cs_n = 1'b1;
    #1;
    check("mr_miso",     {31'd0, bus.OUT_SPI_miso},   32'd1);
    check("mr_rxvalid",  {31'd0, bus.OUT_rxValid},    32'd0);
    check("mr_txready",  {31'd0, bus.OUT_txReady},    32'd1);
    check("mr_underrun", {31'd0, bus.OUT_txUnderrun}, 32'd0);
    check("mr_rxdata",   bus.OUT_rxData,              32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mr_no_deliver", {31'd0, bus.OUT_rxValid}, 32'd0);

    // Rise coincident with cs_n rising after 7 bits
    cs_low();
    xfer(7, 32'h0000_0059, m);
    @(posedge clk); #1;
    bus.IN_SPI_clk  = 1'b0;
    bus.IN_SPI_mosi = 1'b1;
    @(posedge clk); #1;
    bus.IN_SPI_clk  = 1'b1;
    bus.IN_SPI_cs_n = 1'b1;
    @(posedge clk); #1;
    bus.IN_SPI_clk = 1'b0;
    check("co_valid", {31'd0, bus.OUT_rxValid}, 32'd1);
    check("co_bits",  {26'd0, bus.OUT_rxBits},  32'd7);
    check("co_data",  bus.OUT_rxData,           32'h0000_0059);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
